// File: rtl/crc_field_sequencer.sv
// VG93 read-path field sequencer: finds the A1 A1 A1 preamble, classifies ID/data
// fields, counts payload and drives the CRC16 byte unit, reporting pass/fail per field.
module crc_field_sequencer (
    input  logic        iCLK,
    input  logic        iRESET_N,
    input  logic        iENABLE,
    input  logic        iBYTE_VALID,
    input  logic [7:0]  iBYTE,
    input  logic        iSYNC,
    input  logic [15:0] iCRC16,
    output logic        oCRC_RESET,
    output logic        oCRC_STROBE,
    output logic [7:0]  oCRC_BYTE,
    output logic        oBUSY,
    output logic        oFIELD_ID,
    output logic        oDELETED,
    output logic        oDATA_VALID,
    output logic [7:0]  oDATA_BYTE,
    output logic [7:0]  oTRACK,
    output logic [7:0]  oSIDE,
    output logic [7:0]  oSECTOR,
    output logic [1:0]  oSIZE,
    output logic [10:0] oBYTE_CNT,
    output logic        oFIELD_DONE,
    output logic        oCRC_ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_MARK, S_PAYLOAD, S_CRC1, S_CRC2, S_CHECK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_cnt_q, sync_cnt_d;
    logic        pend_q, pend_d;
    logic        chk_wait_q, chk_wait_d;
    logic [10:0] len_q, len_d;
    logic        crc_reset_q, crc_reset_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  crc_byte_q, crc_byte_d;
    logic        busy_q, busy_d;
    logic        field_id_q, field_id_d;
    logic        deleted_q, deleted_d;
    logic        data_valid_q, data_valid_d;
    logic [7:0]  data_byte_q, data_byte_d;
    logic [7:0]  track_q, track_d;
    logic [7:0]  side_q, side_d;
    logic [7:0]  sector_q, sector_d;
    logic [1:0]  size_q, size_d;
    logic [10:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        sync_a1;

    assign sync_a1 = iBYTE_VALID & iSYNC & (iBYTE == 8'hA1);

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        pend_d       = 1'b0;
        chk_wait_d   = chk_wait_q;
        len_d        = len_q;
        strobe_d     = 1'b0;
        crc_byte_d   = crc_byte_q;
        field_id_d   = field_id_q;
        deleted_d    = deleted_q;
        data_valid_d = 1'b0;
        data_byte_d  = data_byte_q;
        track_d      = track_q;
        side_d       = side_q;
        sector_d     = sector_q;
        size_d       = size_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        err_d        = err_q;

        if (!iENABLE) begin
            state_d    = S_IDLE;
            chk_wait_d = 1'b0;
        end else begin
            // Restart A1 is strobed one cycle after the CRC reset pulse it caused
            if (pend_q) begin
                strobe_d   = 1'b1;
                crc_byte_d = 8'hA1;
            end
            case (state_q)
                S_IDLE: begin
                    if (sync_a1) begin
                        state_d    = S_SYNC;
                        sync_cnt_d = 2'd1;
                        strobe_d   = 1'b1;
                        crc_byte_d = iBYTE;
                    end
                end
                S_SYNC: begin
                    if (sync_a1) begin
                        strobe_d   = 1'b1;
                        crc_byte_d = iBYTE;
                        sync_cnt_d = sync_cnt_q + 2'd1;
                        if (sync_cnt_q == 2'd2) state_d = S_MARK;
                    end else if (iBYTE_VALID) begin
                        state_d = S_IDLE;
                    end
                end
                S_MARK, S_PAYLOAD, S_CRC1, S_CRC2: begin
                    if (sync_a1) begin
                        state_d    = S_SYNC;
                        sync_cnt_d = 2'd1;
                        pend_d     = 1'b1;
                    end else if (iBYTE_VALID) begin
                        strobe_d   = 1'b1;
                        crc_byte_d = iBYTE;
                        if (state_q == S_MARK) begin
                            cnt_d = '0;
                            if (iBYTE == 8'hFE) begin
                                state_d    = S_PAYLOAD;
                                len_d      = 11'd4;
                                field_id_d = 1'b1;
                            end else if (iBYTE == 8'hFB || iBYTE == 8'hF8) begin
                                state_d    = S_PAYLOAD;
                                len_d      = 11'd128 << size_q;
                                field_id_d = 1'b0;
                                deleted_d  = (iBYTE == 8'hF8);
                            end else begin
                                state_d = S_IDLE;
                                cnt_d   = cnt_q;
                            end
                        end else if (state_q == S_PAYLOAD) begin
                            cnt_d = cnt_q + 11'd1;
                            if (field_id_q) begin
                                case (cnt_q[1:0])
                                    2'd0:    track_d  = iBYTE;
                                    2'd1:    side_d   = iBYTE;
                                    2'd2:    sector_d = iBYTE;
                                    default: size_d   = iBYTE[1:0];
                                endcase
                            end else begin
                                data_valid_d = 1'b1;
                                data_byte_d  = iBYTE;
                            end
                            if (cnt_q + 11'd1 == len_q) state_d = S_CRC1;
                        end else if (state_q == S_CRC1) begin
                            state_d = S_CRC2;
                        end else begin
                            state_d    = S_CHECK;
                            chk_wait_d = 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    // First cycle lets the CRC unit absorb the final strobe
                    if (!chk_wait_q) begin
                        chk_wait_d = 1'b1;
                    end else begin
                        chk_wait_d = 1'b0;
                        err_d      = (iCRC16 != 16'h0000);
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        crc_reset_d = (state_d == S_IDLE) | pend_d;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET_N) begin
            state_q      <= S_IDLE;
            sync_cnt_q   <= '0;
            pend_q       <= 1'b0;
            chk_wait_q   <= 1'b0;
            len_q        <= 11'd4;
            crc_reset_q  <= 1'b1;
            strobe_q     <= 1'b0;
            crc_byte_q   <= '0;
            busy_q       <= 1'b0;
            field_id_q   <= 1'b0;
            deleted_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_byte_q  <= '0;
            track_q      <= '0;
            side_q       <= '0;
            sector_q     <= '0;
            size_q       <= 2'd1;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            pend_q       <= pend_d;
            chk_wait_q   <= chk_wait_d;
            len_q        <= len_d;
            crc_reset_q  <= crc_reset_d;
            strobe_q     <= strobe_d;
            crc_byte_q   <= crc_byte_d;
            busy_q       <= busy_d;
            field_id_q   <= field_id_d;
            deleted_q    <= deleted_d;
            data_valid_q <= data_valid_d;
            data_byte_q  <= data_byte_d;
            track_q      <= track_d;
            side_q       <= side_d;
            sector_q     <= sector_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign oCRC_RESET  = crc_reset_q;
    assign oCRC_STROBE = strobe_q;
    assign oCRC_BYTE   = crc_byte_q;
    assign oBUSY       = busy_q;
    assign oFIELD_ID   = field_id_q;
    assign oDELETED    = deleted_q;
    assign oDATA_VALID = data_valid_q;
    assign oDATA_BYTE  = data_byte_q;
    assign oTRACK      = track_q;
    assign oSIDE       = side_q;
    assign oSECTOR     = sector_q;
    assign oSIZE       = size_q;
    assign oBYTE_CNT   = cnt_q;
    assign oFIELD_DONE = done_q;
    assign oCRC_ERR    = err_q;

endmodule

// File: tb/tb_crc_field_sequencer.sv
// Scoreboard bench for crc_field_sequencer with a behavioural CCITT CRC16 byte unit.
module tb_crc_field_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, en, bv, isync;
    logic [7:0]  ibyte;
    logic [15:0] unit_crc = 16'hFFFF;

    logic        oCRC_RESET, oCRC_STROBE, oBUSY, oFIELD_ID, oDELETED;
    logic        oDATA_VALID, oFIELD_DONE, oCRC_ERR;
    logic [7:0]  oCRC_BYTE, oDATA_BYTE, oTRACK, oSIDE, oSECTOR;
    logic [1:0]  oSIZE;
    logic [10:0] oBYTE_CNT;

    typedef struct {
        logic        err;
        logic        fid;
        logic        del;
        logic [10:0] cnt;
        logic [7:0]  trk;
        logic [7:0]  sec;
        logic [1:0]  sz;
    } done_t;

    logic [7:0] exp_strobe[$];
    logic [7:0] exp_data[$];
    done_t      exp_done[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drv_cyc = 0;
    int strobe_cnt = 0;

    logic [7:0] e_trk = 8'h00;
    logic [7:0] e_sec = 8'h00;
    logic [1:0] e_sz  = 2'd1;
    logic       e_del = 1'b0;

    crc_field_sequencer dut (
        .iCLK        (clk),
        .iRESET_N    (rst_n),
        .iENABLE     (en),
        .iBYTE_VALID (bv),
        .iBYTE       (ibyte),
        .iSYNC       (isync),
        .iCRC16      (unit_crc),
        .oCRC_RESET  (oCRC_RESET),
        .oCRC_STROBE (oCRC_STROBE),
        .oCRC_BYTE   (oCRC_BYTE),
        .oBUSY       (oBUSY),
        .oFIELD_ID   (oFIELD_ID),
        .oDELETED    (oDELETED),
        .oDATA_VALID (oDATA_VALID),
        .oDATA_BYTE  (oDATA_BYTE),
        .oTRACK      (oTRACK),
        .oSIDE       (oSIDE),
        .oSECTOR     (oSECTOR),
        .oSIZE       (oSIZE),
        .oBYTE_CNT   (oBYTE_CNT),
        .oFIELD_DONE (oFIELD_DONE),
        .oCRC_ERR    (oCRC_ERR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [7:0] pat(input int i);
        int v;
        v = (i * 37 + 11) & 255;
        return v[7:0];
    endfunction

    // CRC16 byte unit: reset has priority over the strobe
    always @(posedge clk) begin
        if (oCRC_RESET) unit_crc <= 16'hFFFF;
        else if (oCRC_STROBE) unit_crc <= crc_upd(unit_crc, oCRC_BYTE);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (oCRC_STROBE) begin
            strobe_cnt++;
            if (exp_strobe.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe_unexpected: got byte %0h expected none", oCRC_BYTE);
            end else begin
                chk("crc_byte", oCRC_BYTE, exp_strobe.pop_front());
            end
        end
        if (oDATA_VALID) begin
            chk("data_with_strobe", oCRC_STROBE, 1);
            if (exp_data.size() == 0) begin
                checks++; errors++;
                $display("FAIL data_unexpected: got byte %0h expected none", oDATA_BYTE);
            end else begin
                chk("data_byte", oDATA_BYTE, exp_data.pop_front());
            end
        end
        if (oFIELD_DONE) begin
            if (exp_done.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: got done pulse expected none");
            end else begin
                done_t d;
                d = exp_done.pop_front();
                chk("done_crc_err", oCRC_ERR, d.err);
                chk("done_field_id", oFIELD_ID, d.fid);
                chk("done_deleted", oDELETED, d.del);
                chk("done_byte_cnt", oBYTE_CNT, d.cnt);
                chk("done_track", oTRACK, d.trk);
                chk("done_sector", oSECTOR, d.sec);
                chk("done_size", oSIZE, d.sz);
                chk("done_latency", cyc - drv_cyc, 3);
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic s, input bit strb);
        @(negedge clk);
        if (strb) exp_strobe.push_back(b);
        ibyte   = b;
        isync   = s;
        bv      = 1'b1;
        drv_cyc = cyc;
        @(negedge clk);
        bv    = 1'b0;
        isync = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_done.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done pulse expected one within 20 cycles");
            exp_done.delete();
        end
    endtask

    // stop_at >= 0 leaves the field after that many payload bytes (no CRC, no done)
    task automatic run_field(input int n_a1, input logic [7:0] mark, input int n_pay,
                             input int stop_at, input logic [7:0] crc_xor, input logic [31:0] id);
        logic [15:0] c;
        logic [7:0]  b;
        done_t       d;
        int          s0;
        bit          is_id;
        is_id = (mark == 8'hFE);
        s0 = strobe_cnt;
        c = 16'hFFFF;
        for (int i = 0; i < 3; i++) c = crc_upd(c, 8'hA1);
        for (int i = 0; i < n_a1; i++) send(8'hA1, 1'b1, 1'b1);
        c = crc_upd(c, mark);
        if (!is_id) e_del = (mark == 8'hF8);
        send(mark, 1'b0, 1'b1);
        for (int i = 0; i < n_pay; i++) begin
            if (stop_at >= 0 && i == stop_at) return;
            b = is_id ? id[31 - 8*i -: 8] : pat(i);
            if (is_id) begin
                if (i == 0) e_trk = b;
                if (i == 2) e_sec = b;
                if (i == 3) e_sz = b[1:0];
            end else begin
                exp_data.push_back(b);
            end
            c = crc_upd(c, b);
            send(b, 1'b0, 1'b1);
        end
        d.err = (crc_xor != 8'h00);
        d.fid = is_id;
        d.del = e_del;
        d.cnt = n_pay[10:0];
        d.trk = e_trk;
        d.sec = e_sec;
        d.sz  = e_sz;
        exp_done.push_back(d);
        send(c[15:8], 1'b0, 1'b1);
        send(c[7:0] ^ crc_xor, 1'b0, 1'b1);
        wait_done();
        chk("strobe_count", strobe_cnt - s0, 6 + n_pay);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; bv = 1'b0; isync = 1'b0; ibyte = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_crc_reset", oCRC_RESET, 1);
        chk("rst_busy", oBUSY, 0);
        chk("rst_size", oSIZE, 1);
        chk("rst_byte_cnt", oBYTE_CNT, 0);
        chk("rst_crc_err", oCRC_ERR, 0);
        chk("rst_track", oTRACK, 0);

        // good and bad ID fields
        run_field(3, 8'hFE, 4, -1, 8'h00, 32'h05000302);
        chk("id_side", oSIDE, 8'h00);
        run_field(3, 8'hFE, 4, -1, 8'h01, 32'h05000302);

        // normal and deleted data fields at size 2
        run_field(3, 8'hFB, 512, -1, 8'h00, 32'h0);
        run_field(3, 8'hF8, 512, -1, 8'h00, 32'h0);

        // broken preamble and unknown mark
        send(8'hA1, 1'b1, 1'b1);
        send(8'hA1, 1'b1, 1'b1);
        send(8'h4E, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("bad_sync_busy", oBUSY, 0);
        chk("bad_sync_crc_reset", oCRC_RESET, 1);
        for (int i = 0; i < 3; i++) send(8'hA1, 1'b1, 1'b1);
        send(8'h55, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("bad_mark_busy", oBUSY, 0);

        // sync A1 inside a data field restarts the preamble
        run_field(3, 8'hFB, 512, 100, 8'h00, 32'h0);
        @(negedge clk);
        exp_strobe.push_back(8'hA1);
        ibyte = 8'hA1; isync = 1'b1; bv = 1'b1;
        @(negedge clk);
        bv = 1'b0; isync = 1'b0;
        chk("abort_crc_reset", oCRC_RESET, 1);
        chk("abort_no_strobe", oCRC_STROBE, 0);
        chk("abort_busy", oBUSY, 1);
        run_field(2, 8'hFE, 4, -1, 8'h00, 32'h07011103);

        // reset in the middle of a payload
        run_field(3, 8'hFB, 1024, 10, 8'h00, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e_trk = 8'h00; e_sec = 8'h00; e_sz = 2'd1; e_del = 1'b0;
        chk("midrst_busy", oBUSY, 0);
        chk("midrst_size", oSIZE, 1);
        chk("midrst_byte_cnt", oBYTE_CNT, 0);
        chk("midrst_track", oTRACK, 0);
        chk("midrst_crc_reset", oCRC_RESET, 1);
        chk("midrst_field_id", oFIELD_ID, 0);

        // enable drop keeps the previous CRC verdict
        run_field(3, 8'hFE, 4, -1, 8'h80, 32'h09010502);
        run_field(3, 8'hFB, 512, 20, 8'h00, 32'h0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk("en_busy", oBUSY, 0);
        chk("en_crc_err_held", oCRC_ERR, 1);
        chk("en_crc_reset", oCRC_RESET, 1);
        run_field(3, 8'hFB, 512, -1, 8'h00, 32'h0);

        repeat (8) @(negedge clk);
        chk("strobe_queue_empty", exp_strobe.size(), 0);
        chk("data_queue_empty", exp_data.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
